// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: one full-subtractor cell sequenced over
// WIDTH cycles (LSB first) with a start/busy/done handshake.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic             w_d;
  logic             w_bnext;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic             r_bor;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  // Full-subtractor bit cell
  assign w_d     = r_a_sr[0] ^ r_b_sr[0] ^ r_bor;
  assign w_bnext = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_bor);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_count == LAST) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand/result shift datapath and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
      r_bor   <= 1'b0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      r_busy <= (w_next == S_RUN);
      r_done <= (w_next == S_DONE);
      if (w_load) begin
        r_a_sr  <= a;
        r_b_sr  <= b;
        r_bor   <= borrow_in;
        r_res   <= '0;
        r_count <= '0;
      end else if (w_step) begin
        r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
        r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
        r_res   <= {w_d, r_res[WIDTH-1:1]};
        r_bor   <= w_bnext;
        r_count <= r_count + CW'(1);
        if (w_last) begin
          r_diff <= {w_d, r_res[WIDTH-1:1]};
          r_bout <= w_bnext;
        end
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_bout;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: directed WIDTH=8 vectors plus an
// exhaustive WIDTH=4 sweep, checked on done by a decoupled monitor.
module tb_serial_sub_ctrl;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    int         t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q8[$];
  exp_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bout8)
  );

  serial_sub_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .borrow_in(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bout4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Wait (bounded) at a falling edge until the 8-bit DUT can accept a start.
  task automatic wait_ready8();
    int n = 0;
    @(negedge clk);
    while (busy8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("w8_ready_timeout", 32'd1, 32'd0);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input bit push, input logic [7:0] ed, input logic eb);
    exp_t e;
    wait_ready8();
    start8 = 1'b1;
    a8     = a;
    b8     = b;
    bin8   = bin;
    e.d    = ed;
    e.bo   = eb;
    e.t    = cyc + 1 + 8;
    if (push) q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    exp_t e;
    int   r;
    int   n = 0;
    @(negedge clk);
    while (busy4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("w4_ready_timeout", 32'd1, 32'd0);
    r      = int'(a) - int'(b) - int'(bin);
    e.d    = {4'h0, 4'(r)};
    e.bo   = (r < 0);
    e.t    = cyc + 1 + 4;
    start4 = 1'b1;
    a4     = a;
    b4     = b;
    bin4   = bin;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   k;
    rst    = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;

    // Scoreboard monitor: pops one expectation per done pulse
    fork
      forever begin
        @(negedge clk);
        if (done8) begin
          if (q8.size() == 0) chk("w8_unexpected_done", 32'd1, 32'd0);
          else begin
            e = q8.pop_front();
            chk("w8_diff", 32'(diff8), 32'(e.d));
            chk("w8_borrow", 32'(bout8), 32'(e.bo));
            chk("w8_done_cycle", 32'(cyc), 32'(e.t));
          end
        end
        if (done4) begin
          if (q4.size() == 0) chk("w4_unexpected_done", 32'd1, 32'd0);
          else begin
            e = q4.pop_front();
            chk("w4_diff", 32'(diff4), 32'(e.d[3:0]));
            chk("w4_borrow", 32'(bout4), 32'(e.bo));
            chk("w4_done_cycle", 32'(cyc), 32'(e.t));
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_borrow", 32'(bout8), 32'd0);
    chk("rst_w4_diff", 32'(diff4), 32'd0);
    rst = 1'b0;

    // Basic op with busy window: high for 8 cycles, low on the done cycle
    op8(8'h5A, 8'h3C, 1'b0, 1'b1, 8'h1E, 1'b0);
    chk("busy_first", 32'(busy8), 32'd1);
    repeat (7) @(negedge clk);
    chk("busy_last", 32'(busy8), 32'd1);
    @(negedge clk);
    chk("busy_on_done", 32'(busy8), 32'd0);

    op8(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1);
    op8(8'h10, 8'h10, 1'b1, 1'b1, 8'hFF, 1'b1);

    // start held high: three back-to-back ops every 9 cycles
    wait_ready8();
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0;
    k = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      e.d = 8'h7F; e.bo = 1'b0; e.t = k + 8 + 9 * i;
      q8.push_back(e);
    end
    repeat (20) @(negedge clk);
    start8 = 1'b0;

    // Operand inputs scrambled during RUN must not matter
    op8(8'hFF, 8'h0F, 1'b0, 1'b1, 8'hF0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      @(negedge clk);
    end

    // Reset mid-run at count=3: outputs clear, no done follows
    op8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    chk("mid_rst_done", 32'(done8), 32'd0);
    chk("mid_rst_diff", 32'(diff8), 32'd0);
    chk("mid_rst_borrow", 32'(bout8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    op8(8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b1);

    // Exhaustive WIDTH=4 sweep
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          op4(4'(ia), 4'(ib), 1'(ic));

    for (int n = 0; n < 100 && (q8.size() != 0 || q4.size() != 0); n++)
      @(negedge clk);
    while (q8.size() != 0) begin
      e = q8.pop_front();
      chk("w8_missing_done", 32'd0, 32'(e.d));
      if (e.d == 8'h00) chk("w8_missing_done_t", 32'd0, 32'(e.t));
    end
    while (q4.size() != 0) begin
      e = q4.pop_front();
      chk("w4_missing_done_t", 32'd0, 32'(e.t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
